multi_way_traffic_controller: RTL and testbench

//  N-direction intersection controller generalising the two-street sensor controller.

---
 rtl/tlc_pkg.sv | 31 +++
 rtl/rr_next_dir.sv | 29 ++
 rtl/multi_way_traffic_controller.sv | 151 +++++++++++++++
 tb/tb_multi_way_traffic_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the multi-direction traffic controller: state encoding,
// lamp triplet helper and parameter legality check.
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } tlc_state_e;

  // Lamp triplet per direction, bit order {red, yellow, green}.
  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  function automatic logic [2:0] lamp_for(input tlc_state_e s);
    case (s)
      ST_GREEN:  return LAMP_G;
      ST_YELLOW: return LAMP_Y;
      default:   return LAMP_R;
    endcase
  endfunction

  // Yellow and all-red lengths must be reachable by the shared saturating timer.
  function automatic bit tlc_params_ok(input int n_dir, input int g_min, input int g_max,
                                       input int y_cyc, input int ar_cyc);
    return (n_dir >= 2) && (n_dir <= 8) && (g_min >= 1) && (g_max >= g_min) &&
           (y_cyc >= 1) && (y_cyc <= g_max + 1) && (ar_cyc >= 0) && (ar_cyc <= g_max + 1);
  endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Combinational round-robin pick: first pending direction after the active one,
// wrapping, with the active direction itself considered last.
module rr_next_dir #(
  parameter int N_DIR = 3
) (
  input  logic [N_DIR-1:0]         pending_i,
  input  logic [$clog2(N_DIR)-1:0] active_i,
  output logic [$clog2(N_DIR)-1:0] next_o,
  output logic                     valid_o
);

  localparam int AW = $clog2(N_DIR);

  logic [AW-1:0] cand;

  always_comb begin
    next_o  = active_i;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N_DIR; i++) begin
      cand = AW'((int'(active_i) + i) % N_DIR);
      if (!valid_o && pending_i[cand]) begin
        valid_o = 1'b1;
        next_o  = cand;
      end
    end
  end

endmodule

// File: rtl/multi_way_traffic_controller.sv
// N-direction intersection controller: round-robin service of latched requests with
// min/max green, yellow and all-red clearance; all outputs registered.
module multi_way_traffic_controller
  import tlc_pkg::*;
#(
  parameter int N_DIR      = 3,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 8,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_DIR-1:0]         sense_i,
  output logic [N_DIR-1:0]         green_o,
  output logic [N_DIR-1:0]         yellow_o,
  output logic [N_DIR-1:0]         red_o,
  output logic [$clog2(N_DIR)-1:0] active_dir_o,
  output logic [N_DIR-1:0]         pending_o
);

  localparam int AW = $clog2(N_DIR);
  localparam int TW = $clog2(GREEN_MAX + 1);

  localparam logic [TW-1:0] G_MIN_LAST = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] G_MAX_LAST = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] T_SAT      = TW'(GREEN_MAX);
  localparam logic [TW-1:0] Y_LAST     = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] AR_LAST    = TW'((ALLRED_CYC > 0) ? ALLRED_CYC - 1 : 0);

  generate
    if (!tlc_params_ok(N_DIR, GREEN_MIN, GREEN_MAX, YELLOW_CYC, ALLRED_CYC)) begin : g_bad_params
      $error("multi_way_traffic_controller: illegal parameter set");
    end
  endgenerate

  tlc_state_e     state_q, state_d;
  logic [AW-1:0]  active_q, active_d;
  logic [AW-1:0]  next_dir_q, next_dir_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [N_DIR-1:0] pending_q, pending_d;
  logic [N_DIR-1:0] green_q, green_d;
  logic [N_DIR-1:0] yellow_q, yellow_d;
  logic [N_DIR-1:0] red_q, red_d;
  logic           state_entry;
  logic           green_entry;
  logic [2:0]     trip;
  logic [AW-1:0]  rr_next;
  logic           rr_valid;

  rr_next_dir #(.N_DIR(N_DIR)) u_rr (
    .pending_i (pending_q),
    .active_i  (active_q),
    .next_o    (rr_next),
    .valid_o   (rr_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_GREEN;
      active_q   <= '0;
      next_dir_q <= '0;
      timer_q    <= '0;
      pending_q  <= '0;
      green_q    <= N_DIR'(1);
      yellow_q   <= '0;
      red_q      <= {{(N_DIR-1){1'b1}}, 1'b0};
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      next_dir_q <= next_dir_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      green_q    <= green_d;
      yellow_q   <= yellow_d;
      red_q      <= red_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    next_dir_d  = next_dir_q;
    state_entry = 1'b0;
    timer_d     = timer_q;
    pending_d   = pending_q;
    green_d     = '0;
    yellow_d    = '0;
    red_d       = '0;
    trip        = LAMP_R;

    unique case (state_q)
      ST_GREEN: begin
        // >= on the max bound: the timer may already sit saturated after a long idle green.
        if ((timer_q >= G_MIN_LAST) && (|pending_q) &&
            (!sense_i[active_q] || (timer_q >= G_MAX_LAST))) begin
          state_d     = ST_YELLOW;
          state_entry = 1'b1;
        end
      end
      ST_YELLOW: begin
        if (timer_q == Y_LAST) begin
          state_entry = 1'b1;
          next_dir_d  = rr_valid ? rr_next : active_q;
          if (ALLRED_CYC == 0) begin
            state_d  = ST_GREEN;
            active_d = next_dir_d;
          end else begin
            state_d = ST_ALLRED;
          end
        end
      end
      ST_ALLRED: begin
        if (timer_q == AR_LAST) begin
          state_d     = ST_GREEN;
          active_d    = next_dir_q;
          state_entry = 1'b1;
        end
      end
      default: begin
        state_d     = ST_GREEN;
        state_entry = 1'b1;
      end
    endcase

    if (state_entry)
      timer_d = '0;
    else if (timer_q != T_SAT)
      timer_d = timer_q + TW'(1);

    green_entry = state_entry && (state_d == ST_GREEN);

    // The direction entering green is cleared even if it senses on the same edge.
    for (int d = 0; d < N_DIR; d++) begin
      pending_d[d] = !(green_entry && (active_d == AW'(d))) &&
                     (pending_q[d] ||
                      (sense_i[d] && ((active_q != AW'(d)) || (state_q != ST_GREEN))));
      trip        = (active_d == AW'(d)) ? lamp_for(state_d) : LAMP_R;
      green_d[d]  = trip[0];
      yellow_d[d] = trip[1];
      red_d[d]    = trip[2];
    end
  end

  assign green_o      = green_q;
  assign yellow_o     = yellow_q;
  assign red_o        = red_q;
  assign active_dir_o = active_q;
  assign pending_o    = pending_q;

endmodule

// File: tb/tb_multi_way_traffic_controller.sv
// Scoreboard bench for multi_way_traffic_controller (3 directions, 4/8/2/1 timing).
module tb_multi_way_traffic_controller;

  typedef enum int {PG, PY, PR} ph_e;

  typedef struct packed {
    logic [2:0] g;
    logic [2:0] y;
    logic [2:0] r;
    logic [1:0] act;
    logic [2:0] pend;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sense = 3'b000;
  logic [2:0] green, yellow, red, pending;
  logic [1:0] active_dir;

  obs_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   step = 0;
  bit   inv_en = 1'b0;

  multi_way_traffic_controller #(
    .N_DIR(3), .GREEN_MIN(4), .GREEN_MAX(8), .YELLOW_CYC(2), .ALLRED_CYC(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sense_i      (sense),
    .green_o      (green),
    .yellow_o     (yellow),
    .red_o        (red),
    .active_dir_o (active_dir),
    .pending_o    (pending)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input ph_e ph, input int act, input logic [2:0] pend);
    obs_t o;
    logic [2:0] one;
    one    = 3'b001;
    o.g    = (ph == PG) ? (one << act) : 3'b000;
    o.y    = (ph == PY) ? (one << act) : 3'b000;
    o.r    = ~(o.g | o.y);
    o.act  = 2'(act);
    o.pend = pend;
    return o;
  endfunction

  function automatic bit inv_ok(input logic [2:0] g, input logic [2:0] y, input logic [2:0] r);
    int nonred;
    nonred = 0;
    for (int d = 0; d < 3; d++) begin
      if ($countones({g[d], y[d], r[d]}) != 1) return 1'b0;
      if (!r[d]) nonred++;
    end
    return nonred <= 1;
  endfunction

  // Drive inputs for n cycles; each cycle queues the outputs expected after the next edge.
  task automatic cyc(input logic r, input logic [2:0] s, input ph_e ph, input int act,
                     input logic [2:0] pend, input int n);
    repeat (n) begin
      @(negedge clk);
      rst   = r;
      sense = s;
      sb.push_back(mk(ph, act, pend));
    end
  endtask

  always @(posedge clk) begin
    obs_t exp_o, got_o;
    #1;
    if (sb.size() != 0) begin
      exp_o = sb.pop_front();
      got_o = '{g: green, y: yellow, r: red, act: active_dir, pend: pending};
      checks++;
      if (got_o !== exp_o) begin
        failures++;
        $display("FAIL step%0d got g=%b y=%b r=%b act=%0d pend=%b want g=%b y=%b r=%b act=%0d pend=%b",
                 step, got_o.g, got_o.y, got_o.r, got_o.act, got_o.pend,
                 exp_o.g, exp_o.y, exp_o.r, exp_o.act, exp_o.pend);
      end
      step++;
      inv_en = 1'b1;
    end
    if (inv_en) begin
      checks++;
      if (!inv_ok(green, yellow, red)) begin
        failures++;
        $display("FAIL lamp_invariant at t=%0t got g=%b y=%b r=%b want one lamp per dir, <=1 non-red",
                 $time, green, yellow, red);
      end
    end
  end

  initial begin
    // Reset then idle: green stays on direction 0.
    cyc(1, 3'b000, PG, 0, 3'b000, 2);
    cyc(0, 3'b000, PG, 0, 3'b000, 50);

    // Single pulse on direction 1.
    cyc(1, 3'b000, PG, 0, 3'b000, 1);
    cyc(0, 3'b010, PG, 0, 3'b010, 1);
    cyc(0, 3'b000, PG, 0, 3'b010, 2);
    cyc(0, 3'b000, PY, 0, 3'b010, 2);
    cyc(0, 3'b000, PR, 0, 3'b010, 1);
    cyc(0, 3'b000, PG, 1, 3'b000, 3);

    // Direction 0 keeps sensing: green capped at 8; its yellow sense re-latches pending.
    cyc(1, 3'b000, PG, 0, 3'b000, 1);
    cyc(0, 3'b101, PG, 0, 3'b100, 1);
    cyc(0, 3'b001, PG, 0, 3'b100, 6);
    cyc(0, 3'b001, PY, 0, 3'b100, 1);
    cyc(0, 3'b001, PY, 0, 3'b101, 1);
    cyc(0, 3'b001, PR, 0, 3'b101, 1);
    cyc(0, 3'b000, PG, 2, 3'b001, 1);

    // Simultaneous requests 1 and 2, then wrap from 2 back to 0.
    cyc(1, 3'b000, PG, 0, 3'b000, 1);
    cyc(0, 3'b110, PG, 0, 3'b110, 1);
    cyc(0, 3'b000, PG, 0, 3'b110, 2);
    cyc(0, 3'b000, PY, 0, 3'b110, 2);
    cyc(0, 3'b000, PR, 0, 3'b110, 1);
    cyc(0, 3'b000, PG, 1, 3'b100, 4);
    cyc(0, 3'b000, PY, 1, 3'b100, 2);
    cyc(0, 3'b000, PR, 1, 3'b100, 1);
    cyc(0, 3'b000, PG, 2, 3'b000, 2);
    cyc(0, 3'b001, PG, 2, 3'b001, 1);
    cyc(0, 3'b000, PG, 2, 3'b001, 1);
    cyc(0, 3'b000, PY, 2, 3'b001, 2);
    cyc(0, 3'b000, PR, 2, 3'b001, 1);
    cyc(0, 3'b000, PG, 0, 3'b000, 1);

    // From active 2, requests 0 and 1 together: 0 is served first.
    cyc(1, 3'b000, PG, 0, 3'b000, 1);
    cyc(0, 3'b100, PG, 0, 3'b100, 1);
    cyc(0, 3'b000, PG, 0, 3'b100, 2);
    cyc(0, 3'b000, PY, 0, 3'b100, 2);
    cyc(0, 3'b000, PR, 0, 3'b100, 1);
    cyc(0, 3'b000, PG, 2, 3'b000, 1);
    cyc(0, 3'b011, PG, 2, 3'b011, 1);
    cyc(0, 3'b000, PG, 2, 3'b011, 2);
    cyc(0, 3'b000, PY, 2, 3'b011, 2);
    cyc(0, 3'b000, PR, 2, 3'b011, 1);
    cyc(0, 3'b000, PG, 0, 3'b010, 4);
    cyc(0, 3'b000, PY, 0, 3'b010, 2);
    cyc(0, 3'b000, PR, 0, 3'b010, 1);
    cyc(0, 3'b000, PG, 1, 3'b000, 1);

    // Reset during yellow discards pending; a fresh request then sees a full 4-cycle green.
    cyc(1, 3'b000, PG, 0, 3'b000, 1);
    cyc(0, 3'b100, PG, 0, 3'b100, 1);
    cyc(0, 3'b000, PG, 0, 3'b100, 2);
    cyc(0, 3'b000, PY, 0, 3'b100, 1);
    cyc(1, 3'b000, PG, 0, 3'b000, 1);
    cyc(0, 3'b010, PG, 0, 3'b010, 1);
    cyc(0, 3'b000, PG, 0, 3'b010, 2);
    cyc(0, 3'b000, PY, 0, 3'b010, 2);
    cyc(0, 3'b000, PR, 0, 3'b010, 1);
    cyc(0, 3'b000, PG, 1, 3'b000, 1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got %0d entries left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
